frame_block_scanner: RTL and testbench
======================================

FRAME_BLOCK_SCANNER -- requirements
Module: frame_block_scanner

Interface
REQ-001 SHALL have parameter BLOCKS_X, default 80, meaning 4x4-pixel blocks per frame row.
REQ-002 SHALL have parameter BLOCKS_Y, default 60, meaning block rows per frame.
REQ-003 SHALL have parameter FETCH_CYCLES, default 5, meaning cycles the block address is held before frame-memory rows are captured (range 1..15).
REQ-004 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  pulse that begins a frame scan from block 0.
REQ-007 SHALL have port abort  input  1  terminates the scan in progress.
REQ-008 SHALL have port mem_addr  output  13  linear block index driven to the frame memory.
REQ-009 SHALL have ports mem_row0..mem_row3  input  32 each  block rows returned by the frame memory.
REQ-010 SHALL have ports blk_row0..blk_row3  output  32 each  captured block rows.
REQ-011 SHALL have port blk_index  output  13  linear index of the block on blk_row*.
REQ-012 SHALL have ports blk_valid output 1 and blk_ready input 1, the block handshake.
REQ-013 SHALL have ports busy output 1 (scan active) and done output 1 (one-cycle end-of-frame pulse).

Function
REQ-014 SHALL implement states IDLE, FETCH, CAPTURE, HOLD.
REQ-015 IDLE: start=1 -> FETCH next cycle, mem_addr=0; start while not IDLE SHALL be ignored.
REQ-016 FETCH: mem_addr held constant; wait counter counts 0..FETCH_CYCLES-1, then -> CAPTURE.
REQ-017 CAPTURE: mem_row0..3 registered into blk_row0..3, blk_index=mem_addr, blk_valid=1 from next cycle; -> HOLD.
REQ-018 HOLD: blk_valid, blk_row*, blk_index SHALL stay stable until a cycle with blk_valid=1 and blk_ready=1.
REQ-019 On handshake, blk_valid SHALL drop next cycle; if mem_addr < BLOCKS_X*BLOCKS_Y-1, mem_addr increments by 1 and state -> FETCH.
REQ-020 Column counter bx (0..BLOCKS_X-1) and row counter by (0..BLOCKS_Y-1) SHALL track mem_addr; bx wraps to 0 and by increments together on a row end; mem_addr SHALL equal by*BLOCKS_X+bx at all times.
REQ-021 Handshake on last block (index BLOCKS_X*BLOCKS_Y-1, default 4799) SHALL end the frame: done=1 for exactly one cycle, then the behaviour of REQ-032/033.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 abort=1 in any non-IDLE state SHALL force IDLE next cycle, clear blk_valid, clear counters, and SHALL NOT pulse done; abort has priority over a simultaneous handshake.
REQ-024 abort and start in the same IDLE cycle: abort wins, state stays IDLE.
REQ-025 Minimum per-block period with blk_ready tied 1 SHALL be FETCH_CYCLES+2 cycles.
REQ-026 blk_ready SHALL be ignored while blk_valid=0.

Reset
REQ-027 rst=1 SHALL immediately (asynchronously) force state IDLE.
REQ-028 Reset values: mem_addr=0, blk_row0..3=0, blk_index=0, blk_valid=0, busy=0, done=0, bx=by=0, wait counter=0.
REQ-029 Reset mid-scan SHALL discard the block in flight; after deassertion nothing happens until start.
REQ-030 Reset deassertion SHALL be treated as synchronous to clk by the integrating logic.

Configuration
REQ-031 Macro FRAME_LOOP_EN SHALL select end-of-frame behaviour.
REQ-032 FRAME_LOOP_EN defined: after last-block handshake, mem_addr wraps to 0 and state -> FETCH (continuous scanning, busy stays 1); done still pulses once per frame; only abort or rst stops it.
REQ-033 FRAME_LOOP_EN undefined: after last-block handshake, state -> IDLE, mem_addr=0, busy=0.

Verification
REQ-034 rst, start pulse, blk_ready=1, FETCH_CYCLES=5 -> blk_valid first high cycle 7 after start, blk_index=0, blk_row0..3 = memory model rows for block 0.
REQ-035 blk_ready=0 for 20 cycles on block 3 -> blk_row*, blk_index=3 stable all 20 cycles; mem_addr stays 3; block 4 fetched only after handshake.
REQ-036 Full frame, ready=1, BLOCKS_X=80, BLOCKS_Y=60 -> 4800 blocks indices 0..4799 in order, bx wraps 79->0 at index 80, single done pulse; undefined macro -> busy=0 after; FRAME_LOOP_EN -> next blk_index=0.
REQ-037 abort asserted in the same cycle as the handshake on block 10 -> IDLE next cycle, blk_valid=0, no done, mem_addr=0.
REQ-038 rst asserted mid-FETCH of block 100 -> all outputs at reset values without waiting for a clock edge; a later start restarts at block 0.

Source files
------------

// File: rtl/frame_block_scanner_if.sv
// Frame-memory and block-output bundle for frame_block_scanner.
// master = scanner side, slave = memory/consumer side.
interface frame_block_scanner_if;
  logic [12:0] mem_addr;
  logic [31:0] mem_row0;
  logic [31:0] mem_row1;
  logic [31:0] mem_row2;
  logic [31:0] mem_row3;
  logic [31:0] blk_row0;
  logic [31:0] blk_row1;
  logic [31:0] blk_row2;
  logic [31:0] blk_row3;
  logic [12:0] blk_index;
  logic        blk_valid;
  logic        blk_ready;

  modport master (
    output mem_addr, blk_row0, blk_row1, blk_row2, blk_row3, blk_index, blk_valid,
    input  mem_row0, mem_row1, mem_row2, mem_row3, blk_ready
  );

  modport slave (
    input  mem_addr, blk_row0, blk_row1, blk_row2, blk_row3, blk_index, blk_valid,
    output mem_row0, mem_row1, mem_row2, mem_row3, blk_ready
  );
endinterface

// File: rtl/frame_block_scanner.sv
// Walks a frame block by block, fetching 4x4 blocks from frame memory and presenting them
// on a valid/ready handshake. Define FRAME_LOOP_EN for continuous frame-after-frame scanning.
module frame_block_scanner #(
  parameter int BLOCKS_X     = 80,
  parameter int BLOCKS_Y     = 60,
  parameter int FETCH_CYCLES = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  output logic                         busy,
  output logic                         done,
  frame_block_scanner_if.master        bus
);

  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, HOLD} state_t;

  localparam logic [12:0] LAST_BLOCK = 13'(BLOCKS_X * BLOCKS_Y - 1);
  localparam logic [12:0] LAST_BX    = 13'(BLOCKS_X - 1);
  localparam logic [3:0]  LAST_WAIT  = 4'(FETCH_CYCLES - 1);

`ifdef FRAME_LOOP_EN
  localparam state_t END_STATE = FETCH;
`else
  localparam state_t END_STATE = IDLE;
`endif

  state_t      state;
  state_t      state_next;
  logic [3:0]  wait_cnt;
  logic [12:0] bx;
  logic [12:0] by;
  logic        handshake;
  logic        last_block;
  logic        abort_hit;

  // ready only matters while a block is actually on offer
  assign handshake  = bus.blk_valid & bus.blk_ready;
  assign last_block = (bus.mem_addr == LAST_BLOCK);
  assign abort_hit  = abort & (state != IDLE);
  assign busy       = (state != IDLE);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state decode; abort outranks every other transition
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start && !abort) state_next = FETCH;
        else                 state_next = IDLE;
      end
      FETCH: begin
        if (abort)                       state_next = IDLE;
        else if (wait_cnt == LAST_WAIT)  state_next = CAPTURE;
        else                             state_next = FETCH;
      end
      CAPTURE: begin
        if (abort) state_next = IDLE;
        else       state_next = HOLD;
      end
      HOLD: begin
        if (abort)          state_next = IDLE;
        else if (handshake) state_next = last_block ? END_STATE : FETCH;
        else                state_next = HOLD;
      end
      default: state_next = IDLE;
    endcase
  end

  // address/counter walk, block capture and end-of-frame pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_addr  <= 13'd0;
      bus.blk_row0  <= 32'd0;
      bus.blk_row1  <= 32'd0;
      bus.blk_row2  <= 32'd0;
      bus.blk_row3  <= 32'd0;
      bus.blk_index <= 13'd0;
      bus.blk_valid <= 1'b0;
      done          <= 1'b0;
      bx            <= 13'd0;
      by            <= 13'd0;
      wait_cnt      <= 4'd0;
    end else begin
      done <= 1'b0;
      if (abort_hit) begin
        bus.blk_valid <= 1'b0;
        bus.mem_addr  <= 13'd0;
        bx            <= 13'd0;
        by            <= 13'd0;
        wait_cnt      <= 4'd0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              bus.mem_addr <= 13'd0;
              bx           <= 13'd0;
              by           <= 13'd0;
              wait_cnt     <= 4'd0;
            end
          end
          FETCH: begin
            wait_cnt <= (wait_cnt == LAST_WAIT) ? 4'd0 : wait_cnt + 4'd1;
          end
          CAPTURE: begin
            bus.blk_row0  <= bus.mem_row0;
            bus.blk_row1  <= bus.mem_row1;
            bus.blk_row2  <= bus.mem_row2;
            bus.blk_row3  <= bus.mem_row3;
            bus.blk_index <= bus.mem_addr;
            bus.blk_valid <= 1'b1;
          end
          HOLD: begin
            if (handshake) begin
              bus.blk_valid <= 1'b0;
              wait_cnt      <= 4'd0;
              if (last_block) begin
                done         <= 1'b1;
                bus.mem_addr <= 13'd0;
                bx           <= 13'd0;
                by           <= 13'd0;
              end else begin
                bus.mem_addr <= bus.mem_addr + 13'd1;
                if (bx == LAST_BX) begin
                  bx <= 13'd0;
                  by <= by + 13'd1;
                end else begin
                  bx <= bx + 13'd1;
                end
              end
            end
          end
          default: begin
            bus.blk_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_block_scanner.sv
// Self-checking bench for frame_block_scanner: vector table, scoreboard of expected block
// indices, and directed abort/reset/full-frame sequences.
module tb_frame_block_scanner;

  localparam int BX = 80;
  localparam int BY = 60;
  localparam int F  = 5;
  localparam int NBLK = BX * BY;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic abort;
  logic busy;
  logic done;

  frame_block_scanner_if bus ();

  frame_block_scanner #(.BLOCKS_X(BX), .BLOCKS_Y(BY), .FETCH_CYCLES(F)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] row_of(input logic [12:0] a, input int k);
    return {4'(k), 3'b000, a, 12'hABC};
  endfunction

  // frame-memory model: rows depend only on the requested block index
  assign bus.mem_row0 = row_of(bus.mem_addr, 0);
  assign bus.mem_row1 = row_of(bus.mem_addr, 1);
  assign bus.mem_row2 = row_of(bus.mem_addr, 2);
  assign bus.mem_row3 = row_of(bus.mem_addr, 3);

  int total = 0;
  int bad   = 0;
  logic [12:0] exp_q[$];
  logic [12:0] exp_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every accepted block must be the next one expected
  always @(negedge clk) begin
    if (!rst && bus.blk_valid && bus.blk_ready && !abort) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got block %0d expected none", bus.blk_index);
      end else begin
        exp_e = exp_q.pop_front();
        check("sb_index", bus.blk_index, exp_e);
        check("sb_row0", bus.blk_row0, row_of(exp_e, 0));
        check("sb_row1", bus.blk_row1, row_of(exp_e, 1));
        check("sb_row2", bus.blk_row2, row_of(exp_e, 2));
        check("sb_row3", bus.blk_row3, row_of(exp_e, 3));
        check("sb_bx", dut.bx, exp_e % 13'(BX));
        check("sb_by", dut.by, exp_e / 13'(BX));
      end
    end
  end

  typedef struct {
    int          ready_delay;
    int          exp_latency;
    logic [12:0] exp_index;
  } vec_t;

  vec_t vecs[6];

  task automatic check_reset_values(input string tag);
    check({tag, "_mem_addr"}, bus.mem_addr, 13'd0);
    check({tag, "_blk_valid"}, bus.blk_valid, 1'b0);
    check({tag, "_blk_index"}, bus.blk_index, 13'd0);
    check({tag, "_blk_row0"}, bus.blk_row0, 32'd0);
    check({tag, "_blk_row3"}, bus.blk_row3, 32'd0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    int lat;
    int n;
    int dones;
    int delays[6];
    delays = '{0, 2, 0, 20, 1, 0};
    for (int i = 0; i < 6; i++) begin
      vecs[i].ready_delay = delays[i];
      vecs[i].exp_latency = F + 2;
      vecs[i].exp_index   = 13'(i);
    end

    rst = 1'b1; start = 1'b0; abort = 1'b0; bus.blk_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    rst = 1'b0;
    @(posedge clk); #1;

    // table-driven blocks 0..5 with varied ready stalls
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    check("busy_after_start", busy, 1'b1);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(vecs[i].exp_index);
      while (!bus.blk_valid && lat < 60) begin
        @(posedge clk); #1; lat++;
      end
      check($sformatf("latency_blk%0d", i), lat, vecs[i].exp_latency);
      check($sformatf("index_blk%0d", i), bus.blk_index, vecs[i].exp_index);
      for (int d = 0; d < vecs[i].ready_delay; d++) begin
        @(posedge clk); #1;
        check("stall_valid", bus.blk_valid, 1'b1);
        check("stall_index", bus.blk_index, vecs[i].exp_index);
        check("stall_addr", bus.mem_addr, vecs[i].exp_index);
        check("stall_row0", bus.blk_row0, row_of(vecs[i].exp_index, 0));
      end
      bus.blk_ready = 1'b1;
      @(posedge clk); #1;
      bus.blk_ready = 1'b0;
      lat = 1;
      check("valid_drop", bus.blk_valid, 1'b0);
    end

    // abort coincident with the handshake on block 10
    for (int i = 6; i < 10; i++) exp_q.push_back(13'(i));
    bus.blk_ready = 1'b1;
    n = 0;
    while (!(bus.blk_valid && bus.blk_index == 13'd10) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("blk10_reached", bus.blk_valid && bus.blk_index == 13'd10, 1'b1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    bus.blk_ready = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_valid", bus.blk_valid, 1'b0);
    check("abort_mem_addr", bus.mem_addr, 13'd0);
    check("abort_done", done, 1'b0);
    check("abort_sb_drained", exp_q.size(), 0);

    // abort and start together in IDLE: stays IDLE
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    check("abort_start_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_start_idle", busy, 1'b0);

    // asynchronous reset in the middle of fetching block 100
    for (int i = 0; i < 100; i++) exp_q.push_back(13'(i));
    bus.blk_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(busy && !bus.blk_valid && bus.mem_addr == 13'd100) && n < 1500) begin
      @(posedge clk); #1; n++;
    end
    check("fetch100_reached", bus.mem_addr, 13'd100);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_sb_drained", exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_idle", busy, 1'b0);

    // full frame with ready tied high; a stray start mid-scan must be ignored
    for (int i = 0; i < NBLK; i++) exp_q.push_back(13'(i));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    n = 0;
    while (dones == 0 && n < NBLK * (F + 2) + 200) begin
      @(posedge clk); #1; n++;
      if (n == 50) start = 1'b1;
      if (n == 51) start = 1'b0;
      if (done) dones++;
    end
    check("frame_done_seen", dones, 1);
    check("frame_sb_drained", exp_q.size(), 0);
    check("frame_cycles", n, NBLK * (F + 2));
    @(posedge clk); #1;
    check("done_one_cycle", done, 1'b0);
`ifdef FRAME_LOOP_EN
    check("loop_busy", busy, 1'b1);
    exp_q.push_back(13'd0);
    n = 0;
    while (!bus.blk_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("loop_next_index", bus.blk_index, 13'd0);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("loop_abort_busy", busy, 1'b0);
`else
    check("end_busy", busy, 1'b0);
    check("end_mem_addr", bus.mem_addr, 13'd0);
    repeat (F + 3) @(posedge clk);
    #1;
    check("end_no_valid", bus.blk_valid, 1'b0);
`endif
    bus.blk_ready = 1'b0;
    check("final_sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
